// File: rtl/mx_int8_block_sequencer.sv
// -----------------------------------------------------------------------------
// mx_int8_block_sequencer
//
// Collects BLOCK_SIZE bf16 elements, derives a shared E8M0 scale from the
// largest exponent in the block, then streams the block back out as MX int8
// elements (two's complement, implicit 2^-6 weight relative to the scale).
// Fill and emit phases alternate; they never overlap.
//
// Ports
//   clk_i        : clock, all state updates on the rising edge
//   rst_i        : asynchronous active-high reset
//   clear_i      : synchronous abort of the current block
//   in_valid_i   : bf16 element valid
//   in_ready_o   : sequencer accepts an element (high during FILL)
//   in_data_i    : bf16 element {sign, exp[7:0], mant[6:0]}
//   out_valid_o  : quantized element valid (high during EMIT)
//   out_ready_i  : consumer accepts an element
//   out_data_o   : MX int8 element
//   out_scale_o  : shared E8M0 block scale
//   out_last_o   : marks element BLOCK_SIZE-1 of a block
// -----------------------------------------------------------------------------
module mx_int8_block_sequencer #(
    parameter int BLOCK_SIZE = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] in_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [7:0]  out_data_o,
    output logic [7:0]  out_scale_o,
    output logic        out_last_o
);

    localparam int               CNT_W    = $clog2(BLOCK_SIZE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_SIZE - 1);

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;
    logic [7:0]       max_exp_q, scale_q;
    logic             nan_flag_q;
    logic [15:0]      mem_q [BLOCK_SIZE];

    logic             in_fire, out_fire;
    logic [7:0]       in_exp, max_exp_d;
    logic             nan_flag_d;

    // bf16 -> int8 at the given block scale, round-to-nearest-even, saturating.
    function automatic logic [7:0] quantize(input logic [15:0] elem,
                                            input logic [7:0]  scale);
        logic [7:0]  exp_v;
        logic [7:0]  sig;
        logic [8:0]  sh;
        logic [15:0] shifted;
        logic [7:0]  q;
        logic [7:0]  rem;
        logic        round_up;
        logic [8:0]  mag;
        logic [7:0]  res;

        exp_v    = elem[14:7];
        sig      = {1'b1, elem[6:0]};
        // Nine bits so a (never expected) exponent above the scale wraps
        // to a large shift and flushes to zero instead of overflowing.
        sh       = 9'd1 + {1'b0, scale} - {1'b0, exp_v};
        shifted  = 16'h0000;
        q        = 8'h00;
        rem      = 8'h00;
        round_up = 1'b0;
        mag      = 9'h000;
        res      = 8'h00;

        if (scale != 8'hFF && exp_v != 8'h00 && sh < 9'd9) begin
            // Keep the discarded bits in the low byte to decide rounding.
            shifted  = {sig, 8'h00} >> sh[3:0];
            q        = shifted[15:8];
            rem      = shifted[7:0];
            round_up = (rem > 8'h80) || ((rem == 8'h80) && q[0]);
            mag      = {1'b0, q} + {8'h00, round_up};
            if (mag > 9'd127) begin
                mag = 9'd127;
            end
            res = elem[15] ? (~mag[7:0] + 8'd1) : mag[7:0];
        end
        return res;
    endfunction

    // A cycle with clear_i high never completes a handshake.
    assign in_fire    = in_valid_i  & (state_q == FILL) & ~clear_i;
    assign out_fire   = out_ready_i & (state_q == EMIT) & ~clear_i;

    assign in_exp     = in_data_i[14:7];
    assign max_exp_d  = (in_exp > max_exp_q) ? in_exp : max_exp_q;
    assign nan_flag_d = nan_flag_q | (in_exp == 8'hFF);

    // ---------------------------------------------------------------- FSM ---
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FILL;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop
            // samples pre-edge values, whatever the block ordering.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the block leaves state_d
        // unassigned and infers a latch.
        state_d = state_q;
        if (clear_i) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL: if (in_fire  && wr_cnt_q == LAST_IDX) state_d = EMIT;
                EMIT: if (out_fire && rd_cnt_q == LAST_IDX) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    // ----------------------------------------------------------- datapath ---
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            max_exp_q  <= 8'h00;
            nan_flag_q <= 1'b0;
            scale_q    <= 8'h00;
        end else if (clear_i) begin
            // The scale deliberately survives an abort.
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            max_exp_q  <= 8'h00;
            nan_flag_q <= 1'b0;
        end else if (in_fire) begin
            wr_cnt_q   <= wr_cnt_q + 1'b1;  // wraps to 0 after the last element
            max_exp_q  <= max_exp_d;
            nan_flag_q <= nan_flag_d;
            if (wr_cnt_q == LAST_IDX) begin
                scale_q <= nan_flag_d ? 8'hFF : max_exp_d;
            end
        end else if (out_fire) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
            if (rd_cnt_q == LAST_IDX) begin
                rd_cnt_q   <= '0;
                max_exp_q  <= 8'h00;
                nan_flag_q <= 1'b0;
            end
        end
    end

    // NOTE: the element buffer has no reset; only entries written in the
    // current block are ever read, so resetting it would buy nothing.
    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            mem_q[wr_cnt_q] <= in_data_i;
        end
    end

    // ------------------------------------------------------------ outputs ---
    assign in_ready_o  = (state_q == FILL);
    assign out_valid_o = (state_q == EMIT);
    assign out_scale_o = scale_q;
    // Gated outside EMIT so unwritten buffer entries never reach the port.
    assign out_data_o  = (state_q == EMIT) ? quantize(mem_q[rd_cnt_q], scale_q) : 8'h00;
    assign out_last_o  = (state_q == EMIT) && (rd_cnt_q == LAST_IDX);

endmodule

// File: tb/tb_mx_int8_block_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mx_int8_block_sequencer
//
// Scoreboard bench: each fed block pushes its expected outputs to a queue,
// which is popped as the DUT emits elements.
// -----------------------------------------------------------------------------
module tb_mx_int8_block_sequencer;

    localparam int N = 32;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] scale;
        logic       last;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  out_data_o;
    logic [7:0]  out_scale_o;
    logic        out_last_o;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb_q[$];
    logic [15:0] blk [N];
    logic [7:0]  exp_data [N];

    mx_int8_block_sequencer #(.BLOCK_SIZE(N)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_scale_o (out_scale_o),
        .out_last_o  (out_last_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: value / (2^(scale-127) * 2^-6) = sig * 2^-(1+scale-e),
    // computed by integer division with explicit remainder-based RNE.
    function automatic logic [7:0] model_q(input logic [15:0] x, input logic [7:0] scale);
        int     e;
        int     sc;
        int     sh;
        longint s;
        longint dv;
        longint q;
        longint r;
        e  = int'(x[14:7]);
        sc = int'(scale);
        if (sc == 255 || e == 0) return 8'h00;
        s  = 128 + longint'(x[6:0]);
        sh = 1 + sc - e;
        if (sh < 1 || sh > 20) return 8'h00;
        dv = longint'(1) << sh;
        q  = s / dv;
        r  = s % dv;
        if ((2 * r > dv) || ((2 * r == dv) && (q % 2 == 1))) q = q + 1;
        if (q > 127) q = 127;
        return x[15] ? 8'(-q) : 8'(q);
    endfunction

    function automatic logic [7:0] model_scale();
        int mx;
        mx = 0;
        for (int i = 0; i < N; i++) begin
            if (blk[i][14:7] == 8'hFF) return 8'hFF;
            if (int'(blk[i][14:7]) > mx) mx = int'(blk[i][14:7]);
        end
        return 8'(mx);
    endfunction

    task automatic push_model();
        logic [7:0] sc;
        sc = model_scale();
        for (int i = 0; i < N; i++) sb_q.push_back('{model_q(blk[i], sc), sc, i == N - 1});
    endtask

    task automatic push_const(input logic [7:0] sc);
        for (int i = 0; i < N; i++) sb_q.push_back('{exp_data[i], sc, i == N - 1});
    endtask

    task automatic random_block();
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) blk[i] = 16'h0000;
            else blk[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(8'h70, 8'h86)),
                           7'($urandom_range(0, 127))};
        end
    endtask

    task automatic feed_block();
        for (int i = 0; i < N; i++) begin
            @(negedge clk_i);
            in_valid_i = 1'b1;
            in_data_i  = blk[i];
            checks++;
            if (in_ready_o !== 1'b1) begin
                failures++;
                $display("FAIL fill_in_ready idx=%0d got=%b want=1", i, in_ready_o);
            end
            checks++;
            if (out_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL fill_out_valid idx=%0d got=%b want=0", i, out_valid_o);
            end
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL first_valid_latency got=%b want=1", out_valid_o);
        end
    endtask

    // Sample at negedge; a handshake is taken at the following posedge.
    task automatic drain(input bit rand_ready, input int max_hs);
        int   hs;
        int   cycles;
        exp_t e;
        hs     = 0;
        cycles = 0;
        while (hs < max_hs && cycles < 400) begin
            @(negedge clk_i);
            cycles++;
            out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty got=0 entries want=>0");
                break;
            end
            e = sb_q[0];
            checks++;
            if (in_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL emit_in_ready got=%b want=0", in_ready_o);
            end
            checks++;
            if (out_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL emit_valid got=%b want=1", out_valid_o);
            end
            checks++;
            if (out_data_o !== e.data) begin
                failures++;
                $display("FAIL emit_data hs=%0d got=%h want=%h", hs, out_data_o, e.data);
            end
            checks++;
            if (out_scale_o !== e.scale) begin
                failures++;
                $display("FAIL emit_scale hs=%0d got=%h want=%h", hs, out_scale_o, e.scale);
            end
            checks++;
            if (out_last_o !== e.last) begin
                failures++;
                $display("FAIL emit_last hs=%0d got=%b want=%b", hs, out_last_o, e.last);
            end
            if (out_ready_i) begin
                void'(sb_q.pop_front());
                hs++;
            end
        end
        checks++;
        if (hs != max_hs) begin
            failures++;
            $display("FAIL handshake_count got=%0d want=%0d", hs, max_hs);
        end
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || out_last_o !== 1'b0 || out_data_o !== 8'h00) begin
            failures++;
            $display("FAIL %s got rdy=%b vld=%b last=%b data=%h want rdy=1 vld=0 last=0 data=00",
                     tag, in_ready_o, out_valid_o, out_last_o, out_data_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_idle("reset_outputs");
        checks++;
        if (out_scale_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_scale got=%h want=00", out_scale_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        check_idle("post_reset_idle");
    endtask

    task automatic test_ones();
        for (int i = 0; i < N; i++) begin
            blk[i]      = 16'h3F80;
            exp_data[i] = 8'h40;
        end
        push_const(8'h7F);
        feed_block();
        drain(1'b0, N);
        @(negedge clk_i);
        check_idle("ones_back_to_fill");
    endtask

    task automatic test_rounding();
        for (int i = 0; i < N; i++) begin
            blk[i]      = 16'h0000;
            exp_data[i] = 8'h00;
        end
        blk[0] = 16'h3FC0; exp_data[0] = 8'h60;
        blk[1] = 16'h3F00; exp_data[1] = 8'h20;
        blk[2] = 16'hBF80; exp_data[2] = 8'hC0;
        blk[3] = 16'h3FFF; exp_data[3] = 8'h7F;
        blk[4] = 16'h3F81; exp_data[4] = 8'h40;
        blk[5] = 16'h3F83; exp_data[5] = 8'h42;
        push_const(8'h7F);
        feed_block();
        drain(1'b0, N);
    endtask

    task automatic test_nan();
        for (int i = 0; i < N; i++) begin
            blk[i]      = 16'h3F80;
            exp_data[i] = 8'h00;
        end
        blk[7] = 16'h7FC0;
        push_const(8'hFF);
        feed_block();
        drain(1'b0, N);
    endtask

    task automatic test_zero_block();
        for (int i = 0; i < N; i++) begin
            blk[i]      = (i % 3 == 0) ? 16'h8003 : ((i % 3 == 1) ? 16'h0005 : 16'h0000);
            exp_data[i] = 8'h00;
        end
        push_const(8'h00);
        feed_block();
        drain(1'b0, N);
    endtask

    task automatic test_stall_random();
        random_block();
        push_model();
        feed_block();
        drain(1'b1, N);
    endtask

    task automatic test_clear();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            in_valid_i = 1'b1;
            in_data_i  = (i == 3) ? 16'h7FC0 : 16'h4700;
        end
        @(negedge clk_i);
        clear_i   = 1'b1;
        in_data_i = 16'h7FC0;  // must not be accepted in the clear cycle
        @(negedge clk_i);
        clear_i    = 1'b0;
        in_valid_i = 1'b0;
        check_idle("clear_idle");
        for (int i = 0; i < N; i++) begin
            blk[i]      = 16'h3F80;
            exp_data[i] = 8'h40;
        end
        push_const(8'h7F);
        feed_block();
        drain(1'b0, N);
    endtask

    task automatic test_reset_mid_emit();
        for (int i = 0; i < N; i++) blk[i] = 16'h3F80;
        push_model();
        feed_block();
        drain(1'b0, 5);
        rst_i = 1'b1;
        #1;
        check_idle("reset_mid_emit");
        checks++;
        if (out_scale_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_emit_scale got=%h want=00", out_scale_o);
        end
        sb_q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        random_block();
        push_model();
        feed_block();
        drain(1'b0, N);
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 2; b++) begin
            random_block();
            push_model();
            feed_block();
            drain(1'b0, N);
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        clear_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = 16'h0000;
        out_ready_i = 1'b0;
        test_reset();
        test_ones();
        test_rounding();
        test_nan();
        test_zero_block();
        test_stall_random();
        test_clear();
        test_reset_mid_emit();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
